// File: rtl/tx_char_framer.sv
// Transmit character framer: byte FIFO plus SOF/EOF/idle/filler generator for the 8b/10b encoder.
// Define TX_FRAMER_ALIGN_EN to insert a K28.5 after every ALIGN_PERIOD data characters in a frame.
module tx_char_framer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int MIN_IDLE     = 2,
    parameter int ALIGN_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] o_data,
    output logic       o_kin,
    output logic       o_frame_active,
    output logic       o_underrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (MIN_IDLE > 1) ? $clog2(MIN_IDLE + 1) : 1;

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOF  = 8'hFB;
    localparam logic [7:0] K_EOF  = 8'hFD;
    localparam logic [7:0] K_FILL = 8'hF7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_EOF
    } state_t;

    state_t        state, state_nxt;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [8:0]    head;
    logic          push, pop, empty;
    logic [IW-1:0] idle_cnt, idle_nxt, idle_inc;
    logic [7:0]    data_nxt;
    logic          kin_nxt, active_nxt, under_nxt;
    logic          align_due;

    assign s_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

`ifdef TX_FRAMER_ALIGN_EN
    localparam int AW = $clog2(ALIGN_PERIOD + 1);
    logic [AW-1:0] align_cnt;

    assign align_due = (align_cnt == AW'(ALIGN_PERIOD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            align_cnt <= '0;
        else if (state == ST_SOF || (state == ST_DATA && align_due))
            align_cnt <= '0;
        else if (pop)
            align_cnt <= align_cnt + 1'b1;
    end
`else
    // never true; keeps the parameter referenced in this build
    assign align_due = (ALIGN_PERIOD < 0);
`endif

    // counts the idle being emitted this cycle, so EOF->SOF carries exactly MIN_IDLE idles
    assign idle_inc = (idle_cnt == IW'(MIN_IDLE)) ? idle_cnt : idle_cnt + 1'b1;

    always_comb begin
        state_nxt  = state;
        idle_nxt   = idle_cnt;
        data_nxt   = K_IDLE;
        kin_nxt    = 1'b1;
        active_nxt = 1'b0;
        under_nxt  = 1'b0;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                idle_nxt = idle_inc;
                if (idle_inc == IW'(MIN_IDLE) && !empty)
                    state_nxt = ST_SOF;
            end
            ST_SOF: begin
                data_nxt   = K_SOF;
                active_nxt = 1'b1;
                state_nxt  = ST_DATA;
            end
            ST_DATA: begin
                active_nxt = 1'b1;
                if (align_due) begin
                    data_nxt = K_IDLE;
                end else if (empty) begin
                    data_nxt  = K_FILL;
                    under_nxt = 1'b1;
                end else begin
                    pop      = 1'b1;
                    data_nxt = head[7:0];
                    kin_nxt  = 1'b0;
                    if (head[8])
                        state_nxt = ST_EOF;
                end
            end
            ST_EOF: begin
                data_nxt   = K_EOF;
                active_nxt = 1'b1;
                idle_nxt   = '0;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            idle_cnt       <= '0;
            o_data         <= K_IDLE;
            o_kin          <= 1'b1;
            o_frame_active <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            state          <= state_nxt;
            idle_cnt       <= idle_nxt;
            o_data         <= data_nxt;
            o_kin          <= kin_nxt;
            o_frame_active <= active_nxt;
            o_underrun     <= under_nxt;
        end
    end

endmodule

// File: tb/tb_tx_char_framer.sv
// Testbench for tx_char_framer: directed frames plus random traffic against a frame-level model.
module tb_tx_char_framer;

    localparam int DEPTH = 8;
    localparam int MINI  = 2;
    localparam int APER  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] o_data;
    logic       o_kin;
    logic       o_frame_active;
    logic       o_underrun;

    tx_char_framer #(
        .FIFO_DEPTH  (DEPTH),
        .MIN_IDLE    (MINI),
        .ALIGN_PERIOD(APER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .o_data        (o_data),
        .o_kin         (o_kin),
        .o_frame_active(o_frame_active),
        .o_underrun    (o_underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit align_on;

    logic [7:0] obs_d[$];
    logic       obs_k[$];
    logic       obs_fa[$];
    logic       obs_u[$];
    logic       obs_rdy[$];
    logic       obs_acc[$];

    task automatic clear_obs();
        obs_d.delete();
        obs_k.delete();
        obs_fa.delete();
        obs_u.delete();
        obs_rdy.delete();
        obs_acc.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, output logic acc);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        acc = v && s_ready;
        obs_d.push_back(o_data);
        obs_k.push_back(o_kin);
        obs_fa.push_back(o_frame_active);
        obs_u.push_back(o_underrun);
        obs_rdy.push_back(s_ready);
        obs_acc.push_back(acc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int idx);
        logic a = 1'b0;
        int tries = 0;
        while (!a && tries < 200) begin
            step(1'b1, d, l, a);
            tries++;
        end
        idx = obs_d.size() - 1;
        if (!a) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout byte %h not accepted in 200 cycles", d);
        end
    endtask

    function automatic int find_fb(input int from);
        for (int j = from; j < obs_d.size(); j++)
            if (obs_k[j] && obs_d[j] == 8'hFB)
                return j;
        return -1;
    endfunction

    function automatic logic [8:0] got_at(input int j);
        if (j >= 0 && j < obs_d.size())
            return {obs_k[j], obs_d[j]};
        return 9'h0EE;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (o_data !== 8'hBC || o_kin !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_out got %b/%h want 1/bc", o_kin, o_data);
        end
        vectors++;
        if (o_frame_active !== 1'b0 || o_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got fa=%b u=%b want 0/0", o_frame_active, o_underrun);
        end
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_obs();
        idle(4);
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (got_at(j) !== 9'h1BC || obs_fa[j] !== 1'b0 || obs_rdy[j] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_idle[%0d] got %h fa=%b rdy=%b want 1bc fa=0 rdy=1",
                         j, got_at(j), obs_fa[j], obs_rdy[j]);
            end
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp[$];
        int k, kd, f, nfa;
        clear_obs();
        idle(5);
        send_byte(8'h11, 1'b0, k);
        send_byte(8'h22, 1'b0, kd);
        send_byte(8'h33, 1'b1, kd);
        idle(8);
        f = find_fb(0);
        vectors++;
        if (f != k + 3) begin
            miscompares++;
            $display("FAIL basic_latency sof at %0d want %0d", f, k + 3);
        end
        exp = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1BC, 9'h1BC};
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got_at(f + i) !== exp[i]) begin
                miscompares++;
                $display("FAIL basic_seq[%0d] got %h want %h", i, got_at(f + i), exp[i]);
            end
        end
        nfa = 0;
        foreach (obs_fa[j]) nfa += int'(obs_fa[j]);
        vectors++;
        if (nfa != 5) begin
            miscompares++;
            $display("FAIL basic_active cycles got %0d want 5", nfa);
        end
    endtask

    task automatic test_underrun();
        logic [8:0] exp[$];
        int k, m, f, nf, nu;
        clear_obs();
        send_byte(8'hA5, 1'b1, k);
        idle(8);
        f = find_fb(0);
        exp = '{9'h1FB, 9'h0A5, 9'h1FD, 9'h1BC, 9'h1BC};
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got_at(f + i) !== exp[i]) begin
                miscompares++;
                $display("FAIL single_seq[%0d] got %h want %h", i, got_at(f + i), exp[i]);
            end
        end
        clear_obs();
        send_byte(8'h01, 1'b0, k);
        idle(5);
        send_byte(8'h02, 1'b1, m);
        idle(8);
        nf = m - k - 3;
        if (nf < 0) nf = 0;
        exp = '{9'h1FB, 9'h001};
        repeat (nf) exp.push_back(9'h1F7);
        exp.push_back(9'h002);
        exp.push_back(9'h1FD);
        f = find_fb(0);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got_at(f + i) !== exp[i]) begin
                miscompares++;
                $display("FAIL underrun_seq[%0d] got %h want %h", i, got_at(f + i), exp[i]);
            end
        end
        for (int i = 0; i < nf; i++) begin
            vectors++;
            if (f < 0 || obs_u[f + 2 + i] !== 1'b1) begin
                miscompares++;
                $display("FAIL underrun_pulse[%0d] got 0 want 1", i);
            end
        end
        nu = 0;
        foreach (obs_u[j]) nu += int'(obs_u[j]);
        vectors++;
        if (nu != nf) begin
            miscompares++;
            $display("FAIL underrun_count got %0d want %0d", nu, nf);
        end
    endtask

    task automatic test_align();
        logic [8:0] exp[$];
        int k, f;
        clear_obs();
        idle(3);
        for (int i = 0; i < 20; i++)
            send_byte(8'(i), i == 19, k);
        idle(10);
        exp.push_back(9'h1FB);
        for (int i = 0; i < 20; i++) begin
            if (align_on && i == APER)
                exp.push_back(9'h1BC);
            exp.push_back({1'b0, 8'(i)});
        end
        exp.push_back(9'h1FD);
        f = find_fb(0);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got_at(f + i) !== exp[i]) begin
                miscompares++;
                $display("FAIL align_seq[%0d] got %h want %h", i, got_at(f + i), exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp[$];
        logic [7:0] b;
        int k, f, accb, dcnt;
        bit saw_full;
        clear_obs();
        for (int fr = 0; fr < 6; fr++) begin
            if (fr > 0)
                exp.push_back(9'h1BC);
            if (fr > 0)
                exp.push_back(9'h1BC);
            exp.push_back(9'h1FB);
            for (int i = 0; i < 2; i++) begin
                b = 8'($urandom);
                exp.push_back({1'b0, b});
                send_byte(b, i == 1, k);
            end
            exp.push_back(9'h1FD);
        end
        idle(60);
        f = find_fb(0);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got_at(f + i) !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b_seq[%0d] got %h want %h", i, got_at(f + i), exp[i]);
            end
        end
        accb = 0;
        dcnt = 0;
        saw_full = 1'b0;
        for (int j = 0; j < obs_d.size(); j++) begin
            if (!obs_k[j]) dcnt++;
            vectors++;
            if (obs_rdy[j] !== ((accb - dcnt) < DEPTH)) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d] got %b want %b", j, obs_rdy[j], (accb - dcnt) < DEPTH);
            end
            if (!obs_rdy[j]) saw_full = 1'b1;
            if (obs_acc[j]) accb++;
        end
        vectors++;
        if (!saw_full) begin
            miscompares++;
            $display("FAIL b2b_full s_ready never dropped, want a drop after %0d bytes", DEPTH);
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] exp[$];
        logic a;
        int i, k, f, nbad;
        bit hit;
        clear_obs();
        i = 0;
        hit = 1'b0;
        for (int t = 0; t < 40 && !hit; t++) begin
            if (i < 10)
                step(1'b1, 8'(8'hC0 + i), i == 9, a);
            else
                step(1'b0, 8'h00, 1'b0, a);
            if (a) i++;
            if (obs_k[$] == 1'b0 && obs_d[$] == 8'hC2) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL midrst_reach byte c2 never seen on output");
        end
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({o_kin, o_data} !== 9'h1BC || o_frame_active !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_async got %b/%h fa=%b rdy=%b want 1/bc fa=0 rdy=1",
                     o_kin, o_data, o_frame_active, s_ready);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_obs();
        idle(6);
        nbad = 0;
        for (int j = 0; j < 6; j++)
            if (got_at(j) !== 9'h1BC || obs_fa[j] !== 1'b0 || obs_rdy[j] !== 1'b1) nbad++;
        vectors++;
        if (nbad != 0) begin
            miscompares++;
            $display("FAIL midrst_idle got %0d non-idle cycles want 0", nbad);
        end
        send_byte(8'hD1, 1'b0, k);
        send_byte(8'hD2, 1'b1, f);
        idle(8);
        f = find_fb(0);
        vectors++;
        if (f != k + 3) begin
            miscompares++;
            $display("FAIL midrst_latency sof at %0d want %0d", f, k + 3);
        end
        exp = '{9'h1FB, 9'h0D1, 9'h0D2, 9'h1FD, 9'h1BC};
        for (int n = 0; n < exp.size(); n++) begin
            vectors++;
            if (got_at(f + n) !== exp[n]) begin
                miscompares++;
                $display("FAIL midrst_seq[%0d] got %h want %h", n, got_at(f + n), exp[n]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] flat[$];
        bit         flast[$];
        logic [8:0] c;
        logic [7:0] d;
        int k, len, pos, gap, dcount, nfr, accb, dcnt;
        bit in_frame, first, need_eof, efa;
        clear_obs();
        for (int fr = 0; fr < 15; fr++) begin
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                d = 8'($urandom);
                flat.push_back(d);
                flast.push_back(b == len - 1);
                if ($urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 4));
                send_byte(d, b == len - 1, k);
            end
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 6));
        end
        idle(80);
        pos = 0;
        gap = 0;
        dcount = 0;
        nfr = 0;
        in_frame = 1'b0;
        first = 1'b1;
        need_eof = 1'b0;
        for (int j = 0; j < obs_d.size(); j++) begin
            c = got_at(j);
            if (!in_frame) begin
                efa = 1'b0;
                if (c == 9'h1FB) begin
                    vectors++;
                    if (!first && gap < MINI) begin
                        miscompares++;
                        $display("FAIL rnd_gap at %0d got %0d idles want >=%0d", j, gap, MINI);
                    end
                    first = 1'b0;
                    in_frame = 1'b1;
                    dcount = 0;
                    efa = 1'b1;
                end else begin
                    vectors++;
                    if (c !== 9'h1BC) begin
                        miscompares++;
                        $display("FAIL rnd_idle at %0d got %h want 1bc", j, c);
                    end
                    gap++;
                end
            end else begin
                efa = 1'b1;
                if (need_eof) begin
                    vectors++;
                    if (c !== 9'h1FD) begin
                        miscompares++;
                        $display("FAIL rnd_eof at %0d got %h want 1fd", j, c);
                    end
                    need_eof = 1'b0;
                    in_frame = 1'b0;
                    gap = 0;
                    nfr++;
                end else if (align_on && dcount == APER) begin
                    vectors++;
                    if (c !== 9'h1BC) begin
                        miscompares++;
                        $display("FAIL rnd_align at %0d got %h want 1bc", j, c);
                    end
                    dcount = 0;
                end else if (!c[8]) begin
                    vectors++;
                    if (pos >= flat.size() || c[7:0] !== flat[pos]) begin
                        miscompares++;
                        $display("FAIL rnd_data at %0d got %h want %h", j, c[7:0],
                                 pos < flat.size() ? flat[pos] : 8'h00);
                    end
                    need_eof = pos < flat.size() && flast[pos];
                    pos++;
                    dcount++;
                end else begin
                    vectors++;
                    if (c !== 9'h1F7) begin
                        miscompares++;
                        $display("FAIL rnd_filler at %0d got %h want 1f7", j, c);
                    end
                end
            end
            vectors++;
            if (obs_fa[j] !== efa || obs_u[j] !== (c == 9'h1F7)) begin
                miscompares++;
                $display("FAIL rnd_flags at %0d got fa=%b u=%b want fa=%b u=%b",
                         j, obs_fa[j], obs_u[j], efa, c == 9'h1F7);
            end
        end
        vectors++;
        if (pos != flat.size() || nfr != 15 || in_frame) begin
            miscompares++;
            $display("FAIL rnd_total got %0d bytes %0d frames want %0d bytes 15 frames",
                     pos, nfr, flat.size());
        end
        accb = 0;
        dcnt = 0;
        for (int j = 0; j < obs_d.size(); j++) begin
            if (!obs_k[j]) dcnt++;
            vectors++;
            if (obs_rdy[j] !== ((accb - dcnt) < DEPTH)) begin
                miscompares++;
                $display("FAIL rnd_ready[%0d] got %b want %b", j, obs_rdy[j], (accb - dcnt) < DEPTH);
            end
            if (obs_acc[j]) accb++;
        end
    endtask

    initial begin
`ifdef TX_FRAMER_ALIGN_EN
        align_on = 1'b1;
`else
        align_on = 1'b0;
`endif
        test_reset();
        test_basic();
        test_underrun();
        test_align();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
